// File: rtl/simd_shader_if.sv
// Host-side bus of the SIMD shader core: program load, run handshake,
// retired-instruction count and debug register read.
interface simd_shader_if #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 8,
  parameter int NREGS      = 8,
  parameter int PROG_DEPTH = 16
);
  localparam int VW      = LANES * LANE_W;
  localparam int RW      = $clog2(NREGS);
  localparam int PW      = $clog2(PROG_DEPTH);
  localparam int INSTR_W = 3 + LANES + 3 * RW;

  logic               prog_we;
  logic [PW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               start;
  logic               busy;
  logic               done;
  logic [PW:0]        instr_count;
  logic [RW-1:0]      rd_addr;
  logic [VW-1:0]      rd_data;

  modport master (
    output prog_we, prog_addr, prog_data, start, rd_addr,
    input  busy, done, instr_count, rd_data
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, rd_addr,
    output busy, done, instr_count, rd_data
  );
endinterface

// File: rtl/simd_shader_core.sv
// Self-sequencing SIMD shader core: program memory, vector register file,
// masked per-lane ALU, registered writeback with WB->EX forwarding.
module simd_shader_core #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 8,
  parameter int NREGS      = 8,
  parameter int PROG_DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  simd_shader_if.slave bus
);
  localparam int VW      = LANES * LANE_W;
  localparam int RW      = $clog2(NREGS);
  localparam int PW      = $clog2(PROG_DEPTH);
  localparam int INSTR_W = 3 + LANES + 3 * RW;
  localparam logic [PW-1:0] LAST_PC = PW'(PROG_DEPTH - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_LDI  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pc_q, pc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic               wb_valid_q, wb_valid_d;
  logic [RW-1:0]      wb_dest_q, wb_dest_d;
  logic [VW-1:0]      wb_data_q, wb_data_d;
  logic [VW-1:0]      rd_data_q, rd_data_d;
  logic [VW-1:0]      regs_q [NREGS];
  logic [VW-1:0]      regs_d [NREGS];
  logic [INSTR_W-1:0] prog_q [PROG_DEPTH];
  logic [INSTR_W-1:0] prog_d [PROG_DEPTH];

  logic [INSTR_W-1:0] instr;
  logic [2:0]         op;
  logic [LANES-1:0]   mask;
  logic [RW-1:0]      dest, src_a, src_b;
  logic [LANE_W-1:0]  imm;
  logic [VW-1:0]      va, vb, vd, ex_data;

  always_comb begin
    instr = prog_q[pc_q];
    op    = instr[INSTR_W-1 -: 3];
    mask  = instr[3*RW +: LANES];
    dest  = instr[2*RW +: RW];
    src_a = instr[RW +: RW];
    src_b = instr[0 +: RW];
    imm   = LANE_W'({src_a, src_b});
    // The pending writeback is newer than the register file.
    va = (wb_valid_q && wb_dest_q == src_a) ? wb_data_q : regs_q[src_a];
    vb = (wb_valid_q && wb_dest_q == src_b) ? wb_data_q : regs_q[src_b];
    vd = (wb_valid_q && wb_dest_q == dest)  ? wb_data_q : regs_q[dest];
  end

  always_comb begin
    logic [LANE_W-1:0] a, b, d, r;
    ex_data = '0;
    for (int l = 0; l < LANES; l++) begin
      a = va[l*LANE_W +: LANE_W];
      b = vb[l*LANE_W +: LANE_W];
      d = vd[l*LANE_W +: LANE_W];
      case (op)
        OP_ADD:  r = a + b;
        OP_SUB:  r = a - b;
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_MUL:  r = a * b;
        OP_LDI:  r = imm;
        default: r = d;
      endcase
      ex_data[l*LANE_W +: LANE_W] = mask[l] ? r : d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    rd_data_d  = regs_q[bus.rd_addr];
    regs_d     = regs_q;
    prog_d     = prog_q;

    if (wb_valid_q) begin
      regs_d[wb_dest_q] = wb_data_q;
      cnt_d             = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.prog_we) prog_d[bus.prog_addr] = bus.prog_data;
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (op == OP_HALT) begin
          state_d = S_DRAIN;
        end else begin
          wb_valid_d = 1'b1;
          wb_dest_d  = dest;
          wb_data_d  = ex_data;
          if (pc_q == LAST_PC) state_d = S_DRAIN;
          else                 pc_d    = pc_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    prog_q <= prog_d;
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      rd_data_q  <= '0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      rd_data_q  <= rd_data_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.instr_count = cnt_q;
  assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_simd_shader_core.sv
// Directed bench for simd_shader_core: default 4x8 configuration plus an
// 8x16 / 16-register instance for the wide immediate/mask case.
module tb_simd_shader_core;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [15:0] HALT = 16'hE000;

  simd_shader_if bus ();
  simd_shader_if #(.LANES(8), .LANE_W(16), .NREGS(16)) bus8 ();

  simd_shader_core u_dut (.clk(clk), .rst(rst), .bus(bus));
  simd_shader_core #(.LANES(8), .LANE_W(16), .NREGS(16)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [3:0] m,
                                      input logic [2:0] d, input logic [2:0] a,
                                      input logic [2:0] b);
    return {op, m, d, a, b};
  endfunction

  function automatic logic [15:0] ldi(input logic [3:0] m, input logic [2:0] d,
                                      input logic [5:0] imm);
    return {3'd6, m, d, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [15:0] w);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[3:0];
    bus.prog_data = w;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    bus.rd_addr = idx[2:0];
    tick();
    v = bus.rd_data;
  endtask

  // Returns the cycle offset from the start cycle to the done cycle.
  task automatic run(input bit poke, output int lat);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    check("busy_first_cycle", bus.busy, 1'b1);
    while (!bus.done && lat < 200) begin
      if (poke && lat == 3) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd10;
        bus.prog_data = HALT;
        bus.start     = 1'b1;
      end
      tick();
      lat++;
      bus.prog_we = 1'b0;
      bus.start   = 1'b0;
    end
    check("busy_in_done", bus.busy, 1'b1);
    tick();
    check("done_single_pulse", bus.done, 1'b0);
    check("busy_after_done", bus.busy, 1'b0);
  endtask

  initial begin
    int lat;
    logic [31:0] v;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] v;
    rst = 1'b1;
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0; bus.start = 0; bus.rd_addr = 0;
    bus8.prog_we = 0; bus8.prog_addr = 0; bus8.prog_data = 0; bus8.start = 0; bus8.rd_addr = 0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_count", bus.instr_count, 5'd0);
    check("reset_rd_data", bus.rd_data, 32'h0);

    // Forwarding of r2 into the ADD, HALT at index 3.
    load(0, ldi(4'hF, 3'd1, 6'd5));
    load(1, ldi(4'hF, 3'd2, 6'd3));
    load(2, enc(3'd0, 4'hF, 3'd3, 3'd1, 3'd2));
    load(3, HALT);
    run(1'b0, lat);
    check("p1_latency", lat, 6);
    check("p1_count", bus.instr_count, 5'd3);
    read_reg(3, v); check("p1_r3", v, 32'h08080808);
    read_reg(1, v); check("p1_r1", v, 32'h05050505);
    read_reg(2, v); check("p1_r2", v, 32'h03030303);

    // Masked SUB: only lanes 0 and 2 change.
    load(0, enc(3'd1, 4'b0101, 3'd3, 3'd3, 3'd1));
    load(1, HALT);
    run(1'b0, lat);
    check("p2_latency", lat, 4);
    check("p2_count", bus.instr_count, 5'd1);
    read_reg(3, v); check("p2_r3", v, 32'h08030803);

    // MUL and SUB wrap, dest forwarding under a partial mask.
    load(0, ldi(4'hF, 3'd1, 6'h10));
    load(1, enc(3'd5, 4'hF, 3'd4, 3'd1, 3'd1));
    load(2, ldi(4'hF, 3'd5, 6'd0));
    load(3, enc(3'd1, 4'hF, 3'd6, 3'd5, 3'd2));
    load(4, ldi(4'hF, 3'd7, 6'd1));
    load(5, ldi(4'b0011, 3'd7, 6'd2));
    load(6, HALT);
    run(1'b0, lat);
    check("p3_latency", lat, 9);
    check("p3_count", bus.instr_count, 5'd6);
    read_reg(4, v); check("p3_r4_mul", v, 32'h00000000);
    read_reg(6, v); check("p3_r6_sub", v, 32'hFDFDFDFD);
    read_reg(7, v); check("p3_r7_mask", v, 32'h01010202);
    read_reg(1, v); check("p3_r1", v, 32'h10101010);

    // Full 16-slot program, no HALT; writes/start during RUN must be ignored.
    load(0, ldi(4'hF, 3'd0, 6'd1));
    load(1, ldi(4'hF, 3'd1, 6'd0));
    for (int i = 2; i < 16; i++) load(i, enc(3'd0, 4'hF, 3'd1, 3'd1, 3'd0));
    run(1'b1, lat);
    check("p4_latency", lat, 18);
    check("p4_count", bus.instr_count, 5'd16);
    read_reg(1, v); check("p4_r1", v, 32'h0E0E0E0E);
    read_reg(0, v); check("p4_r0", v, 32'h01010101);

    // Reset in cycle t+3 of a run.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_count", bus.instr_count, 5'd0);
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      check($sformatf("rst_r%0d", i), v, 32'h0);
    end
    repeat (20) tick();
    read_reg(1, v); check("rst_no_late_wb", v, 32'h0);
    check("rst_still_idle", bus.busy, 1'b0);
    run(1'b0, lat);
    check("rerun_latency", lat, 18);
    check("rerun_count", bus.instr_count, 5'd16);
    read_reg(1, v); check("rerun_r1", v, 32'h0E0E0E0E);

    // Wide configuration: LDI r15 imm 0xFF into lanes 0 and 7.
    bus8.prog_we   = 1'b1;
    bus8.prog_addr = 4'd0;
    bus8.prog_data = {3'd6, 8'h81, 4'hF, 4'hF, 4'hF};
    tick();
    bus8.prog_addr = 4'd1;
    bus8.prog_data = {3'd7, 20'd0};
    tick();
    bus8.prog_we = 1'b0;
    bus8.start   = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 1;
    while (!bus8.done && lat < 200) begin
      tick();
      lat++;
    end
    check("w_latency", lat, 4);
    check("w_count", bus8.instr_count, 5'd1);
    bus8.rd_addr = 4'd15;
    tick();
    check("w_r15", bus8.rd_data, 128'h00FF_0000_0000_0000_0000_0000_0000_00FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
